mips_memory_stage: RTL and testbench

Pipeline stage between the execute stage and the writeback stage. Latches execute results, issues load/store requests to the data SRAM over an addr_ok/data_ok handshake, and aligns and extends load data. Hands op, dest reg, final value, pc, instruction and hi/lo downstream under the valid/allowin/ready_go protocol. Writeback consumes mem_out_op, mem_rf_waddr, mem_value, mem_pc, mem_instruction, mem_hi_value, mem_lo_value and mem_valid_ready_go.

---
 rtl/mips_memory_stage.sv | 200 ++++++++++++++++++++
 tb/tb_mips_memory_stage.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_memory_stage.sv
`default_nettype none
// ============================================================================
// Module   : mips_memory_stage
// Purpose  : MIPS memory stage. Issues data-SRAM loads/stores, aligns and
//            extends load data, hands results to writeback.
//            Optional bypass outputs enabled by defining MEM_FORWARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mips_memory_stage #(
    parameter int OP_W         = 32,
    parameter int MEMREAD_BIT  = 16,
    parameter int MEMWRITE_BIT = 17,
    parameter int SIZE_LSB     = 18
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] exe_out_op,
    input  logic [4:0]      exe_rf_waddr,
    input  logic [31:0]     exe_value,
    input  logic [31:0]     exe_store_data,
    input  logic [31:0]     exe_pc,
    input  logic [31:0]     exe_instruction,
    input  logic [31:0]     exe_hi_value,
    input  logic [31:0]     exe_lo_value,
    input  logic            exe_valid_ready_go,
    output logic            mem_allowin,
    output logic            data_req,
    output logic            data_wr,
    output logic [1:0]      data_size,
    output logic [31:0]     data_addr,
    output logic [31:0]     data_wdata,
    input  logic            data_addr_ok,
    input  logic            data_data_ok,
    input  logic [31:0]     data_rdata,
    output logic [OP_W-1:0] mem_out_op,
    output logic [4:0]      mem_rf_waddr,
    output logic [31:0]     mem_value,
    output logic [31:0]     mem_pc,
    output logic [31:0]     mem_instruction,
    output logic [31:0]     mem_hi_value,
    output logic [31:0]     mem_lo_value,
    output logic            mem_valid,
    output logic            mem_valid_ready_go,
`ifdef MEM_FORWARD_EN
    output logic            mem_fwd_valid,
    output logic [4:0]      mem_fwd_waddr,
    output logic [31:0]     mem_fwd_wdata,
    output logic            mem_fwd_pending,
`endif
    input  logic            wb_allowin
);

    localparam int c_regwrite_bit = 15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_valid;
    logic [OP_W-1:0] r_op;
    logic [4:0]      r_waddr;
    logic [31:0]     r_value;
    logic [31:0]     r_store_data;
    logic [31:0]     r_pc;
    logic [31:0]     r_instr;
    logic [31:0]     r_hi;
    logic [31:0]     r_lo;
    logic [31:0]     r_rdata;

    logic            w_latch;
    logic            w_exe_is_mem;
    logic            w_is_mem;
    logic            w_ready_go;
    logic [2:0]      w_acc;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_load;

    assign w_exe_is_mem = exe_out_op[MEMREAD_BIT] | exe_out_op[MEMWRITE_BIT];
    assign w_is_mem     = r_op[MEMREAD_BIT] | r_op[MEMWRITE_BIT];
    assign w_ready_go   = w_is_mem ? (r_state == S_DONE) : 1'b1;
    assign mem_allowin  = !r_valid | (w_ready_go & wb_allowin);
    assign w_latch      = exe_valid_ready_go & mem_allowin;
    assign w_acc        = r_op[SIZE_LSB +: 3];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_latch && w_exe_is_mem) w_state_nxt = S_REQ;
            S_REQ:   if (data_addr_ok) w_state_nxt = S_WAIT;
            S_WAIT:  if (data_data_ok) w_state_nxt = S_DONE;
            S_DONE:  if (wb_allowin)
                         w_state_nxt = (w_latch && w_exe_is_mem) ? S_REQ : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_op         <= '0;
            r_waddr      <= '0;
            r_value      <= '0;
            r_store_data <= '0;
            r_pc         <= '0;
            r_instr      <= '0;
            r_hi         <= '0;
            r_lo         <= '0;
        end else if (w_latch) begin
            r_valid      <= 1'b1;
            r_op         <= exe_out_op;
            r_waddr      <= exe_rf_waddr;
            r_value      <= exe_value;
            r_store_data <= exe_store_data;
            r_pc         <= exe_pc;
            r_instr      <= exe_instruction;
            r_hi         <= exe_hi_value;
            r_lo         <= exe_lo_value;
        end else if (mem_allowin) begin
            r_valid      <= 1'b0;
        end
    end

    // Only a response arriving while waiting is captured; stray data_ok is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (r_state == S_WAIT && data_data_ok) begin
            r_rdata <= data_rdata;
        end
    end

    always_comb begin
        data_size  = 2'd2;
        data_wdata = r_store_data;
        case (w_acc)
            3'b001, 3'b010: begin
                data_size  = 2'd0;
                data_wdata = {4{r_store_data[7:0]}};
            end
            3'b011, 3'b100: begin
                data_size  = 2'd1;
                data_wdata = {2{r_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (r_value[1:0])
            2'd0:    w_byte = r_rdata[7:0];
            2'd1:    w_byte = r_rdata[15:8];
            2'd2:    w_byte = r_rdata[23:16];
            default: w_byte = r_rdata[31:24];
        endcase
        w_half = r_value[1] ? r_rdata[31:16] : r_rdata[15:0];
        case (w_acc)
            3'b001:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b010:  w_load = {24'd0, w_byte};
            3'b011:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {16'd0, w_half};
            default: w_load = r_rdata;
        endcase
    end

    assign data_req           = (r_state == S_REQ);
    assign data_wr            = r_op[MEMWRITE_BIT];
    assign data_addr          = r_value;
    assign mem_value          = r_op[MEMREAD_BIT] ? w_load : r_value;
    assign mem_out_op         = r_op;
    assign mem_rf_waddr       = r_waddr;
    assign mem_pc             = r_pc;
    assign mem_instruction    = r_instr;
    assign mem_hi_value       = r_hi;
    assign mem_lo_value       = r_lo;
    assign mem_valid          = r_valid;
    assign mem_valid_ready_go = r_valid & w_ready_go;

`ifdef MEM_FORWARD_EN
    assign mem_fwd_valid   = r_valid & r_op[c_regwrite_bit];
    assign mem_fwd_waddr   = r_waddr;
    assign mem_fwd_wdata   = mem_value;
    assign mem_fwd_pending = r_valid & r_op[MEMREAD_BIT] & (r_state != S_DONE);
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_memory_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_memory_stage
// Purpose  : Self-checking bench for mips_memory_stage with an SRAM responder
//            and a behavioural model of load alignment and handoff order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_memory_stage;

    logic        clk, rst;
    logic [31:0] exe_out_op, exe_value, exe_store_data, exe_pc, exe_instruction;
    logic [31:0] exe_hi_value, exe_lo_value;
    logic [4:0]  exe_rf_waddr;
    logic        exe_valid_ready_go;
    logic        mem_allowin, data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] mem_out_op, mem_value, mem_pc, mem_instruction, mem_hi_value, mem_lo_value;
    logic [4:0]  mem_rf_waddr;
    logic        mem_valid, mem_valid_ready_go, wb_allowin;

    int n_checks = 0;
    int n_pass   = 0;

    // responder controls
    bit          slave_on = 1'b1;
    bit          rand_delay = 1'b0;
    bit          use_fixed = 1'b0;
    bit          stray_ok = 1'b0;
    int          addr_delay = 0;
    int          data_delay = 0;
    logic [31:0] fixed_rdata = '0;

    bit          mon_on = 1'b0;
    logic [68:0] got_q[$];

    mips_memory_stage dut (
        .clk(clk), .rst(rst),
        .exe_out_op(exe_out_op), .exe_rf_waddr(exe_rf_waddr), .exe_value(exe_value),
        .exe_store_data(exe_store_data), .exe_pc(exe_pc), .exe_instruction(exe_instruction),
        .exe_hi_value(exe_hi_value), .exe_lo_value(exe_lo_value),
        .exe_valid_ready_go(exe_valid_ready_go), .mem_allowin(mem_allowin),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_out_op(mem_out_op), .mem_rf_waddr(mem_rf_waddr), .mem_value(mem_value),
        .mem_pc(mem_pc), .mem_instruction(mem_instruction), .mem_hi_value(mem_hi_value),
        .mem_lo_value(mem_lo_value), .mem_valid(mem_valid),
        .mem_valid_ready_go(mem_valid_ready_go), .wb_allowin(wb_allowin)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // memory contents are a fixed hash of the word address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        return w * 32'h9E37_79B1 + 32'h0F0F_1234;
    endfunction

    function automatic logic [31:0] mk_op(input logic [2:0] acc, input bit rd,
                                          input bit wr, input bit rw);
        logic [31:0] op;
        op = $urandom;
        op[15] = rw;
        op[16] = rd;
        op[17] = wr;
        op[20:18] = acc;
        return op;
    endfunction

    function automatic logic [31:0] model_value(input logic [31:0] op,
                                                input logic [31:0] addr,
                                                input logic [31:0] rdata);
        int unsigned sh, acc;
        logic [31:0] b, h;
        if (!op[16]) return addr;
        acc = op[20:18];
        sh  = addr[1:0];
        b = (rdata >> (8 * sh)) & 32'hFF;
        h = (rdata >> (16 * (sh / 2))) & 32'hFFFF;
        case (acc)
            1: return (b >= 32'd128) ? b - 32'd256 : b;
            2: return b;
            3: return (h >= 32'd32768) ? h - 32'd65536 : h;
            4: return h;
            default: return rdata;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] acc, input logic [31:0] d);
        if (acc == 3'd1 || acc == 3'd2) return (d & 32'hFF) * 32'h0101_0101;
        if (acc == 3'd3 || acc == 3'd4) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [1:0] model_size(input logic [2:0] acc);
        if (acc == 3'd1 || acc == 3'd2) return 2'd0;
        if (acc == 3'd3 || acc == 3'd4) return 2'd1;
        return 2'd2;
    endfunction

    // SRAM responder: one outstanding request, configurable or random delays
    initial begin
        int sst, cnt;
        logic [31:0] req_addr;
        sst = 0; cnt = 0; req_addr = '0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
        forever begin
            @(posedge clk); #2;
            data_addr_ok = 1'b0;
            data_data_ok = 1'b0;
            if (!slave_on) begin
                sst = 0;
                data_data_ok = stray_ok;
                data_rdata = 32'hDEAD_BEEF;
            end else begin
                if (sst == 0 && data_req) begin
                    sst = 1;
                    cnt = rand_delay ? int'($urandom_range(0, 3)) : addr_delay;
                end
                if (sst == 1) begin
                    if (cnt == 0) begin
                        data_addr_ok = 1'b1;
                        req_addr = data_addr;
                        sst = 2;
                        cnt = rand_delay ? int'($urandom_range(0, 3)) : data_delay;
                    end else cnt--;
                end else if (sst == 2) begin
                    if (cnt == 0) begin
                        data_data_ok = 1'b1;
                        data_rdata = use_fixed ? fixed_rdata : mem_word(req_addr);
                        sst = 0;
                    end else cnt--;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mon_on && mem_valid_ready_go === 1'b1 && wb_allowin === 1'b1)
                got_q.push_back({mem_value, mem_rf_waddr, mem_pc});
        end
    end

    // Present one instruction (caller is just after a posedge); returns just after
    // the posedge that latched it.
    task automatic issue(input logic [31:0] op, input logic [4:0] rd,
                         input logic [31:0] val, input logic [31:0] sd, input logic [31:0] pc);
        int k;
        exe_out_op = op; exe_rf_waddr = rd; exe_value = val; exe_store_data = sd;
        exe_pc = pc; exe_instruction = pc ^ 32'hA5A5_0000;
        exe_hi_value = val + 32'd1; exe_lo_value = ~val;
        exe_valid_ready_go = 1'b1;
        k = 0;
        @(negedge clk);
        while (mem_allowin !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (mem_allowin !== 1'b1) begin
            n_checks++;
            $display("FAIL issue_timeout: mem_allowin=%b required 1", mem_allowin);
        end
        @(posedge clk); #1;
        exe_valid_ready_go = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (mem_valid_ready_go === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; wb_allowin = 1'b1;
        exe_out_op = mk_op(3'd1, 1, 0, 1); exe_rf_waddr = 5'd3; exe_value = 32'h55;
        exe_store_data = 0; exe_pc = 32'h10; exe_instruction = 0;
        exe_hi_value = 0; exe_lo_value = 0; exe_valid_ready_go = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({mem_valid, data_req, mem_allowin, mem_valid_ready_go} !== 4'b0010)
            $display("FAIL reset_ctrl: valid/req/allowin/vrg=%b required 0010",
                     {mem_valid, data_req, mem_allowin, mem_valid_ready_go});
        else n_pass++;
        n_checks++;
        if ({mem_out_op, mem_value, mem_pc, mem_rf_waddr} !== '0)
            $display("FAIL reset_regs: op=%h value=%h pc=%h rd=%0d required all 0",
                     mem_out_op, mem_value, mem_pc, mem_rf_waddr);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        exe_valid_ready_go = 1'b0;
    endtask

    task automatic test_alu();
        logic [31:0] op, v;
        @(posedge clk); #1;
        op = mk_op(3'd0, 0, 0, 1);
        issue(op, 5'd9, 32'h1234, 32'hFFFF_0000, 32'h0000_0400);
        @(negedge clk);
        n_checks++;
        if (mem_valid_ready_go !== 1'b1 || mem_value !== 32'h1234 || mem_rf_waddr !== 5'd9)
            $display("FAIL alu_first: vrg=%b value=%h rd=%0d required 1/00001234/9",
                     mem_valid_ready_go, mem_value, mem_rf_waddr);
        else n_pass++;
        n_checks++;
        if (mem_out_op !== op || mem_pc !== 32'h400 || mem_instruction !== 32'hA5A5_0400 ||
            mem_hi_value !== 32'h1235 || mem_lo_value !== ~32'h1234)
            $display("FAIL alu_fields: op=%h pc=%h ins=%h hi=%h lo=%h required %h/400/a5a50400/1235/%h",
                     mem_out_op, mem_pc, mem_instruction, mem_hi_value, mem_lo_value, op, ~32'h1234);
        else n_pass++;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (mem_valid !== 1'b0) $display("FAIL alu_drain: mem_valid=%b required 0", mem_valid);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            v = $urandom;
            issue(mk_op(3'($urandom_range(0, 4)), 0, 0, 1), 5'(i + 1), v, $urandom, 32'h800 + 32'(i));
            @(negedge clk);
            n_checks++;
            if (mem_valid_ready_go !== 1'b1 || mem_value !== v)
                $display("FAIL alu_rand%0d: vrg=%b value=%h required 1/%h", i, mem_valid_ready_go, mem_value, v);
            else n_pass++;
        end
    endtask

    task automatic test_load_directed(input logic [2:0] acc, input logic [31:0] required);
        bit seen;
        @(posedge clk); #1;
        slave_on = 1'b1; rand_delay = 1'b0; addr_delay = 0; data_delay = 0;
        use_fixed = 1'b1; fixed_rdata = 32'h80FF_FFFF; wb_allowin = 1'b1;
        issue(mk_op(acc, 1, 0, 1), 5'd4, 32'h0000_1003, 32'h0, 32'h0000_0500);
        @(negedge clk);
        n_checks++;
        if (data_req !== 1'b1 || data_size !== 2'd0 || data_wr !== 1'b0 ||
            data_addr !== 32'h1003 || mem_valid_ready_go !== 1'b0 || mem_allowin !== 1'b0)
            $display("FAIL load_req: req=%b size=%0d wr=%b addr=%h vrg=%b allowin=%b required 1/0/0/1003/0/0",
                     data_req, data_size, data_wr, data_addr, mem_valid_ready_go, mem_allowin);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (mem_valid_ready_go !== 1'b0) $display("FAIL load_wait: vrg=%b required 0", mem_valid_ready_go);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (mem_valid_ready_go !== 1'b1 || mem_value !== required)
            $display("FAIL load_done acc=%0d: vrg=%b value=%h required 1/%h", acc, mem_valid_ready_go, mem_value, required);
        else n_pass++;
        use_fixed = 1'b0;
    endtask

    task automatic test_load_random();
        logic [31:0] op, addr, req_v;
        logic [2:0]  acc;
        bit seen;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            slave_on = 1'b1; rand_delay = 1'b1; wb_allowin = 1'b1;
            acc  = 3'($urandom_range(0, 4));
            addr = $urandom;
            if (acc == 3'd0) addr[1:0] = 2'b00;
            else if (acc >= 3'd3) addr[0] = 1'b0;
            op = mk_op(acc, 1, 0, 1);
            req_v = model_value(op, addr, mem_word(addr));
            issue(op, 5'd7, addr, 32'h0, 32'h600 + 32'(i));
            wait_done(seen);
            n_checks++;
            if (!seen || mem_value !== req_v || data_size !== model_size(acc))
                $display("FAIL load_rand%0d acc=%0d addr=%h: done=%b value=%h size=%0d required 1/%h/%0d",
                         i, acc, addr, seen, mem_value, data_size, req_v, model_size(acc));
            else n_pass++;
        end
        rand_delay = 1'b0;
    endtask

    task automatic test_store();
        bit ok_seen, done;
        @(posedge clk); #1;
        slave_on = 1'b1; rand_delay = 1'b0; addr_delay = 0; data_delay = 2; wb_allowin = 1'b1;
        issue(mk_op(3'd3, 0, 1, 0), 5'd0, 32'h0000_2002, 32'hABCD_1234, 32'h700);
        @(negedge clk);
        n_checks++;
        if (data_req !== 1'b1 || data_wr !== 1'b1 || data_size !== 2'd1 ||
            data_wdata !== model_wdata(3'd3, 32'hABCD_1234) || data_addr !== 32'h2002)
            $display("FAIL store_req: req=%b wr=%b size=%0d wdata=%h addr=%h required 1/1/1/%h/2002",
                     data_req, data_wr, data_size, data_wdata, data_addr, model_wdata(3'd3, 32'hABCD_1234));
        else n_pass++;
        ok_seen = 1'b0; done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (mem_valid_ready_go === 1'b1) begin done = 1'b1; break; end
            if (data_data_ok === 1'b1) ok_seen = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (!done || !ok_seen || mem_value !== 32'h2002)
            $display("FAIL store_done: done=%b data_ok_before=%b value=%h required 1/1/00002002",
                     done, ok_seen, mem_value);
        else n_pass++;
        data_delay = 0;
    endtask

    task automatic test_addr_stall();
        bit seen;
        @(posedge clk); #1;
        slave_on = 1'b1; rand_delay = 1'b0; addr_delay = 4; data_delay = 0; wb_allowin = 1'b1;
        issue(mk_op(3'd0, 1, 0, 1), 5'd12, 32'h0000_3000, 32'h0, 32'h900);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if ({data_req, data_addr, mem_allowin, mem_valid_ready_go, data_addr_ok} !== {1'b1, 32'h3000, 3'b000})
                $display("FAIL stall_hold%0d: req=%b addr=%h allowin=%b vrg=%b addr_ok=%b required 1/3000/0/0/0",
                         k, data_req, data_addr, mem_allowin, mem_valid_ready_go, data_addr_ok);
            else n_pass++;
        end
        wait_done(seen);
        n_checks++;
        if (!seen || mem_value !== mem_word(32'h3000))
            $display("FAIL stall_done: done=%b value=%h required 1/%h", seen, mem_value, mem_word(32'h3000));
        else n_pass++;
        addr_delay = 0;
    endtask

    task automatic test_back_to_back();
        localparam int N = 40;
        logic [68:0] exp_q[$];
        logic [31:0] op, addr;
        logic [2:0]  acc;
        int kind, cyc;
        bit prod_done;
        @(posedge clk); #1;
        got_q.delete();
        mon_on = 1'b1; slave_on = 1'b1; rand_delay = 1'b1; use_fixed = 1'b0;
        prod_done = 1'b0;
        fork
            begin
                for (int i = 0; i < N; i++) begin
                    kind = $urandom_range(0, 2);
                    acc  = 3'($urandom_range(0, 4));
                    addr = $urandom;
                    if (acc == 3'd0) addr[1:0] = 2'b00;
                    else if (acc >= 3'd3) addr[0] = 1'b0;
                    op = mk_op(acc, kind == 1, kind == 2, kind != 2);
                    exp_q.push_back({model_value(op, addr, mem_word(addr)), 5'(i), 32'h1_0000 + 32'(i)});
                    issue(op, 5'(i), addr, $urandom, 32'h1_0000 + 32'(i));
                    repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
                end
                prod_done = 1'b1;
            end
            begin
                cyc = 0;
                while ((!prod_done || got_q.size() < N) && cyc < 3000) begin
                    @(posedge clk); #1;
                    wb_allowin = ($urandom_range(0, 3) != 0);
                    cyc++;
                end
                wb_allowin = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;
        mon_on = 1'b0; rand_delay = 1'b0;
        n_checks++;
        if (got_q.size() != N)
            $display("FAIL b2b_count: handoffs=%0d required %0d", got_q.size(), N);
        else n_pass++;
        for (int i = 0; i < N && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i])
                $display("FAIL b2b_item%0d: value/rd/pc=%h required %h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        slave_on = 1'b1; rand_delay = 1'b0; addr_delay = 0; data_delay = 10; wb_allowin = 1'b1;
        issue(mk_op(3'd0, 1, 0, 1), 5'd20, 32'h0000_4000, 32'h0, 32'hA00);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; slave_on = 1'b0; stray_ok = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({mem_valid, data_req, mem_allowin, data_data_ok} !== 4'b0011)
            $display("FAIL rstmid_after: valid/req/allowin/stray=%b required 0011",
                     {mem_valid, data_req, mem_allowin, data_data_ok});
        else n_pass++;
        @(posedge clk); #1;
        stray_ok = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({mem_valid, data_req, mem_valid_ready_go} !== 3'b000 || mem_value !== 32'h0 || mem_out_op !== 32'h0)
            $display("FAIL rstmid_stray: valid/req/vrg=%b value=%h op=%h required 000/0/0",
                     {mem_valid, data_req, mem_valid_ready_go}, mem_value, mem_out_op);
        else n_pass++;
        slave_on = 1'b1; data_delay = 0;
        @(posedge clk); #1;
        issue(mk_op(3'd0, 0, 0, 1), 5'd21, 32'h0000_0055, 32'h0, 32'hB00);
        @(negedge clk);
        n_checks++;
        if (mem_valid_ready_go !== 1'b1 || mem_value !== 32'h55 || data_req !== 1'b0)
            $display("FAIL rstmid_recover: vrg=%b value=%h req=%b required 1/00000055/0",
                     mem_valid_ready_go, mem_value, data_req);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_directed(3'd1, 32'hFFFF_FF80);
        test_load_directed(3'd2, 32'h0000_0080);
        test_load_random();
        test_store();
        test_addr_stall();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
